alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal range 4..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op  input  4  operation code {Ainvert,Binvert,AluOp} style, see REQ-012.
REQ-007 a, b  input  WIDTH each  operands, sampled on accept.
REQ-008 out_valid  output  1  result present.
REQ-009 out_ready  input  1  consumer takes result.
REQ-010 result  output  WIDTH  primary result (product low half / quotient).
REQ-011 result_hi, zero, div0, bad_op  output  WIDTH,1,1,1  product high half / remainder; result==0; divide-by-zero; unsupported op.

Function
REQ-012 Opcodes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT signed (result 1 or 0), 1100 NOR, 1000 MULU, 1001 DIVU; all others unsupported.
REQ-013 FSM SHALL have states IDLE, CALC, DONE; reset state IDLE.
REQ-014 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; in_ready=1 only in IDLE.
REQ-015 On accept, a, b, op SHALL be registered; later operand changes have no effect.
REQ-016 Logic/arith ops and unsupported ops SHALL go IDLE->DONE; out_valid asserts the cycle after accept (latency 1).
REQ-017 ADD/SUB SHALL wrap modulo 2^WIDTH; carry/overflow discarded; result_hi=0.
REQ-018 Unsupported op SHALL give result=0, result_hi=0, bad_op=1, zero=1.
REQ-019 MULU SHALL go IDLE->CALC, run unsigned shift-add for exactly WIDTH CALC cycles, then DONE; out_valid asserts WIDTH+1 cycles after accept; {result_hi,result} = full 2*WIDTH product.
REQ-020 DIVU SHALL run unsigned restoring division, same timing as MULU; result=quotient, result_hi=remainder.
REQ-021 DIVU with b=0 SHALL still take WIDTH+1 cycles and return result=all ones, result_hi=a, div0=1.
REQ-022 div0 and bad_op SHALL be 0 for every other case.
REQ-023 zero SHALL reflect result (low half only) and be valid whenever out_valid=1.
REQ-024 In DONE, out_valid=1 and result/result_hi/zero/div0/bad_op SHALL hold stable until out_ready=1 sampled; then state returns to IDLE, out_valid=0 next cycle.
REQ-025 No new request SHALL be accepted in the cycle DONE is left; earliest next accept is one cycle later (in_ready rises with IDLE).
REQ-026 in_valid during CALC or DONE SHALL be ignored and not queued.
REQ-027 Iteration counter SHALL be ceil(log2(WIDTH+1)) bits and SHALL not wrap within one operation.
REQ-028 Outputs other than in_ready/out_valid SHALL be don't-care-free: registered values, never X after reset.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, in_ready=1, out_valid=0, result=0, result_hi=0, zero=1, div0=0, bad_op=0, counter=0.
REQ-030 Reset asserted in CALC or DONE SHALL abort the operation; no out_valid for it after release.
REQ-031 After rst_n deasserts, first accept SHALL be possible on the first rising edge with in_valid=1.

Verification
REQ-032 WIDTH=32: ADD a=0xFFFFFFFF b=1 -> one cycle later out_valid=1, result=0, zero=1; SLT a=0xFFFFFFFF b=1 -> result=1.
REQ-033 WIDTH=32: MULU a=0xFFFFFFFF b=0xFFFFFFFF -> out_valid exactly 33 cycles after accept, result_hi=0xFFFFFFFE, result=0x00000001.
REQ-034 WIDTH=32: DIVU a=100 b=7 -> result=14, result_hi=2; DIVU a=5 b=0 -> result=0xFFFFFFFF, result_hi=5, div0=1, 33-cycle latency.
REQ-035 Backpressure: hold out_ready=0 for 10 cycles after out_valid on SUB a=3 b=5 -> result=0xFFFFFFFE stable all 10 cycles, in_ready=0, extra in_valid ignored.
REQ-036 Reset mid-MULU (cycle 10 of CALC) -> outputs at reset values immediately, no out_valid after release; then op=1010 -> bad_op=1, result=0.
REQ-037 WIDTH=8 build: MULU a=0xFF b=0x02 -> 9-cycle latency, result_hi=0x01, result=0xFE.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU with a ready/valid request and result handshake.
// Logic and add/sub ops finish one cycle after accept. MULU and DIVU use a
// bit-serial datapath that runs for WIDTH iterations. The result stays held
// until the consumer takes it.
module alu_mc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             div0,
    output logic             bad_op
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] opnd;      // multiplicand (MULU) or divisor (DIVU)
    logic [WIDTH-1:0] acc_hi;    // partial product high / running remainder
    logic [WIDTH-1:0] acc_lo;    // multiplier bits / dividend-then-quotient bits
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] quick_res;
    logic             quick_bad;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    // Single-cycle operations, evaluated directly from the request operands
    always_comb begin
        quick_res = '0;
        quick_bad = 1'b0;
        case (op)
            OP_AND:  quick_res = a & b;
            OP_OR:   quick_res = a | b;
            OP_ADD:  quick_res = a + b;
            OP_SUB:  quick_res = a - b;
            OP_SLT:  quick_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_NOR:  quick_res = ~(a | b);
            default: quick_bad = 1'b1;
        endcase
    end

    // One shift-add or restoring-division iteration on the accumulators.
    // A zero divisor always passes the compare. This leaves an all-ones
    // quotient and the dividend as the remainder without needing a special case.
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        ge      = shifted >= {1'b0, opnd};
        diff    = shifted[WIDTH-1:0] - opnd;
        step_hi = '0;
        step_lo = '0;
        if (op_r == OP_MULU) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end else if (ge) begin
            step_hi = diff;
            step_lo = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            step_hi = shifted[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b1;
            div0      <= 1'b0;
            bad_op    <= 1'b0;
            cnt       <= '0;
            op_r      <= '0;
            opnd      <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_r     <= op;
                        in_ready <= 1'b0;
                        if (op == OP_MULU || op == OP_DIVU) begin
                            state  <= CALC;
                            cnt    <= '0;
                            opnd   <= (op == OP_MULU) ? a : b;
                            acc_hi <= '0;
                            acc_lo <= (op == OP_MULU) ? b : a;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= quick_res;
                            result_hi <= '0;
                            zero      <= (quick_res == '0);
                            div0      <= 1'b0;
                            bad_op    <= quick_bad;
                        end
                    end
                end
                CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= step_lo;
                        result_hi <= step_hi;
                        zero      <= (step_lo == '0);
                        div0      <= (op_r == OP_DIVU) && (opnd == '0);
                        bad_op    <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc. A WIDTH=32 instance is checked every cycle against a
// transaction-level model. Directed vectors with literal expectations are
// also applied. A WIDTH=8 instance covers the narrow-width multiply.
module tb_alu_mc;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic        zero;
    logic        div0;
    logic        bad_op;

    logic        in_valid8;
    logic        in_ready8;
    logic [3:0]  op8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        out_valid8;
    logic        out_ready8;
    logic [7:0]  result8;
    logic [7:0]  result_hi8;
    logic        zero8;
    logic        div08;
    logic        bad_op8;

    int tests;
    int fails;
    bit cmp_en;

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op_i), .a(a_i), .b(b_i), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi), .zero(zero), .div0(div0), .bad_op(bad_op)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .result_hi(result_hi8), .zero(zero8), .div0(div08), .bad_op(bad_op8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: what an op must produce and how long it takes
    task automatic model_op(input logic [3:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                            output logic [31:0] res, output logic [31:0] hi,
                            output logic dz, output logic bad, output int lat);
        logic [63:0] prod;
        res = 0; hi = 0; dz = 0; bad = 0; lat = 1;
        case (mop)
            4'b0000: res = ma & mb;
            4'b0001: res = ma | mb;
            4'b0010: res = ma + mb;
            4'b0110: res = ma - mb;
            4'b0111: res = ($signed(ma) < $signed(mb)) ? 32'd1 : 32'd0;
            4'b1100: res = ~(ma | mb);
            4'b1000: begin
                prod = {32'd0, ma} * {32'd0, mb};
                res = prod[31:0];
                hi = prod[63:32];
                lat = 33;
            end
            4'b1001: begin
                lat = 33;
                if (mb == 0) begin
                    res = 32'hFFFF_FFFF; hi = ma; dz = 1;
                end else begin
                    res = ma / mb; hi = ma % mb;
                end
            end
            default: bad = 1;
        endcase
    endtask

    logic        m_ready, m_valid, m_fresh;
    int          m_wait;
    logic [31:0] m_res, m_hi, p_res, p_hi;
    logic        m_div0, m_bad, p_div0, p_bad;
    int          p_lat;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready = 1; m_valid = 0; m_fresh = 1; m_wait = 0;
            m_res = 0; m_hi = 0; m_div0 = 0; m_bad = 0;
        end else if (m_ready && in_valid) begin
            model_op(op_i, a_i, b_i, p_res, p_hi, p_div0, p_bad, p_lat);
            m_ready = 0;
            m_fresh = 0;
            m_wait = p_lat - 1;
            if (m_wait == 0) begin
                m_valid = 1; m_res = p_res; m_hi = p_hi; m_div0 = p_div0; m_bad = p_bad;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 0;
            m_ready = 1;
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                m_valid = 1; m_res = p_res; m_hi = p_hi; m_div0 = p_div0; m_bad = p_bad;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_in_ready", in_ready, m_ready);
            chk("m_out_valid", out_valid, m_valid);
            if (m_valid || m_fresh) begin
                chk("m_result", result, m_res);
                chk("m_result_hi", result_hi, m_hi);
                chk("m_zero", zero, m_res == 0);
                chk("m_div0", div0, m_div0);
                chk("m_bad_op", bad_op, m_bad);
            end
        end
    end

    // Start at a negedge, end at a negedge. With extra=1, in_valid stays high
    // from after the accept through the release edge.
    task automatic run_vec(input string name, input logic [3:0] vop, input logic [31:0] va,
                           input logic [31:0] vb, input logic [31:0] er, input logic [31:0] eh,
                           input logic ed, input logic eb, input int elat,
                           input int hold, input bit extra);
        int n;
        bit got;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_ready"}, in_ready, 1);
        op_i = vop; a_i = va; b_i = vb; in_valid = 1;
        @(posedge clk);
        #1;
        in_valid = extra;
        op_i = 4'($urandom_range(15));
        a_i = $urandom;
        b_i = $urandom;
        n = 0;
        got = 0;
        while (n < 100 && !got) begin
            @(negedge clk);
            n++;
            if (out_valid) got = 1;
        end
        chk({name, "_latency"}, n, elat);
        chk({name, "_result"}, result, er);
        chk({name, "_result_hi"}, result_hi, eh);
        chk({name, "_zero"}, zero, er == 0);
        chk({name, "_div0"}, div0, ed);
        chk({name, "_bad_op"}, bad_op, eb);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, "_hold_result"}, result, er);
            chk({name, "_hold_in_ready"}, in_ready, 0);
            chk({name, "_hold_out_valid"}, out_valid, 1);
        end
        out_ready = 1;
        @(posedge clk);
        #1;
        out_ready = 0;
        in_valid = 0;
        @(negedge clk);
        chk({name, "_released"}, out_valid, 0);
        if (extra) chk({name, "_no_accept_on_exit"}, in_ready, 1);
    endtask

    initial begin
        int n;
        bit seen;
        tests = 0; fails = 0; cmp_en = 0;
        rst_n = 1; in_valid = 0; out_ready = 0; op_i = 0; a_i = 0; b_i = 0;
        in_valid8 = 0; out_ready8 = 0; op8 = 0; a8 = 0; b8 = 0;
        #3 rst_n = 0;
        @(negedge clk);
        cmp_en = 1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 1);
        chk("rst8_in_ready", in_ready8, 1);
        rst_n = 1;

        run_vec("add_wrap",  4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0, 0, 1, 0, 0);
        run_vec("slt_neg",   4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0, 0, 1, 0, 0);
        run_vec("slt_pos",   4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd0, 0, 0, 0, 1, 0, 0);
        run_vec("and",       4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 0, 0, 0, 1, 0, 0);
        run_vec("or",        4'b0001, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 0, 0, 0, 1, 0, 0);
        run_vec("nor",       4'b1100, 32'd0, 32'd0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 0);
        run_vec("mulu_max",  4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 0, 0, 33, 0, 1);
        run_vec("mulu_small",4'b1000, 32'h0001_2345, 32'h10, 32'h0012_3450, 0, 0, 0, 33, 0, 0);
        run_vec("divu",      4'b1001, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 33, 0, 0);
        run_vec("divu_zero", 4'b1001, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1, 0, 33, 0, 0);
        run_vec("sub_hold",  4'b0110, 32'd3, 32'd5, 32'hFFFF_FFFE, 0, 0, 0, 1, 10, 1);
        run_vec("bad_0011",  4'b0011, 32'd9, 32'd9, 32'd0, 0, 0, 1, 1, 0, 0);

        // Abort a multiply partway through CALC
        op_i = 4'b1000; a_i = 32'hFFFF_FFFF; b_i = 32'hFFFF_FFFF; in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        repeat (10) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_result", result, 0);
        chk("abort_result_hi", result_hi, 0);
        chk("abort_zero", zero, 1);
        chk("abort_div0", div0, 0);
        chk("abort_bad_op", bad_op, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("abort_no_valid", seen, 0);
        run_vec("bad_1010", 4'b1010, 32'd123, 32'd456, 32'd0, 0, 0, 1, 1, 0, 0);

        // Narrow-width multiply on the WIDTH=8 instance
        op8 = 4'b1000; a8 = 8'hFF; b8 = 8'h02; in_valid8 = 1;
        @(posedge clk);
        #1 in_valid8 = 0;
        a8 = 8'h55;
        b8 = 8'hAA;
        n = 0;
        while (n < 50 && !out_valid8) begin
            @(negedge clk);
            n++;
        end
        chk("w8_latency", n, 9);
        chk("w8_result_hi", result_hi8, 8'h01);
        chk("w8_result", result8, 8'hFE);
        chk("w8_div0", div08, 0);
        out_ready8 = 1;
        @(posedge clk);
        #1 out_ready8 = 0;
        @(negedge clk);
        chk("w8_released", out_valid8, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL timeout: simulation did not complete, fails=%0d", fails);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
